tag_ram_ctrl: RTL and testbench

Controller and arbiter for a single-port synchronous-read tag RAM (registered read address, data valid one cycle after the address is presented). It shares the RAM between a lookup requester and an update (fill/invalidate) requester, and clears every entry after reset or on flush. Each lookup returns a one-cycle hit/miss response. The block sits between the cache pipeline and the tag RAM instance.

---
 rtl/tag_ram_ctrl.sv | 111 +++++++++++
 tb/tb_tag_ram_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_ram_ctrl.sv
// tag_ram_ctrl: init sweep, flush and round-robin lookup/update arbitration for a sync-read tag RAM; optional TAG_RAM_CTRL_STATS_EN adds hit/miss counters
module tag_ram_ctrl #(
    parameter int AWIDTH = 3,
    parameter int TWIDTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lk_valid,
    output logic              lk_ready,
    input  logic [AWIDTH-1:0] lk_index,
    input  logic [TWIDTH-1:0] lk_tag,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [AWIDTH-1:0] rsp_index,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [AWIDTH-1:0] up_index,
    input  logic [TWIDTH-1:0] up_tag,
    input  logic              up_set_valid,
    input  logic              flush_req,
    output logic              init_done,
`ifdef TAG_RAM_CTRL_STATS_EN
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count,
`endif
    output logic [AWIDTH-1:0] ram_addr,
    output logic [TWIDTH:0]   ram_din,
    output logic              ram_we,
    input  logic [TWIDTH:0]   ram_dout
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            r_state;
    logic [AWIDTH-1:0] r_cnt;
    logic [AWIDTH-1:0] r_lk_index;
    logic [TWIDTH-1:0] r_lk_tag;
    logic              r_rr_up;
    logic              r_rsp_valid;
    logic              w_run;
    logic              w_up_gnt;
    logic              w_lk_gnt;
    logic              w_init;

    assign w_init    = r_state == INIT;
    assign w_run     = (r_state == RUN) & ~flush_req;
    assign w_up_gnt  = w_run & up_valid & (~lk_valid | r_rr_up);
    assign w_lk_gnt  = w_run & lk_valid & (~up_valid | ~r_rr_up);
    assign up_ready  = w_up_gnt;
    assign lk_ready  = w_lk_gnt;
    assign init_done = r_state == RUN;
    assign rsp_valid = r_rsp_valid;
    assign rsp_index = r_lk_index;
    assign rsp_hit   = r_rsp_valid & ram_dout[TWIDTH] & (ram_dout[TWIDTH-1:0] == r_lk_tag);

    // RAM port mux: sweep writes zeros, update writes its word, lookup only drives the address
    always_comb begin
        ram_we   = w_init ? ~reset : w_up_gnt;
        ram_addr = w_init ? r_cnt : w_up_gnt ? up_index : w_lk_gnt ? lk_index : '0;
        ram_din  = w_up_gnt ? {up_set_valid, up_tag} : '0;
    end

    // State, sweep counter, round-robin pointer and lookup capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= INIT;
            r_cnt       <= '0;
            r_rr_up     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_lk_index  <= '0;
            r_lk_tag    <= '0;
        end else begin
            r_rsp_valid <= w_lk_gnt;
            if (w_lk_gnt) begin
                r_lk_index <= lk_index;
                r_lk_tag   <= lk_tag;
            end
            if (lk_valid & up_valid & (w_up_gnt | w_lk_gnt))
                r_rr_up <= w_lk_gnt;
            if (w_init) begin
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
                if (r_cnt == LAST)
                    r_state <= RUN;
            end else if (flush_req) begin
                r_state <= INIT;
                r_cnt   <= '0;
            end
        end
    end

`ifdef TAG_RAM_CTRL_STATS_EN
    // Saturating hit/miss counters, cleared whenever a flush is taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if ((r_state == RUN) & flush_req) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (r_rsp_valid) begin
            if (rsp_hit & (hit_count != 16'hFFFF))
                hit_count <= hit_count + 16'd1;
            if (~rsp_hit & (miss_count != 16'hFFFF))
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// tb_tag_ram_ctrl: directed bench for tag_ram_ctrl with a behavioural sync-read RAM
module tb_tag_ram_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       lk_valid = 1'b0;
    logic       lk_ready;
    logic [2:0] lk_index = '0;
    logic [7:0] lk_tag = '0;
    logic       rsp_valid;
    logic       rsp_hit;
    logic [2:0] rsp_index;
    logic       up_valid = 1'b0;
    logic       up_ready;
    logic [2:0] up_index = '0;
    logic [7:0] up_tag = '0;
    logic       up_set_valid = 1'b0;
    logic       flush_req = 1'b0;
    logic       init_done;
    logic [2:0] ram_addr;
    logic [8:0] ram_din;
    logic       ram_we;
    logic [8:0] ram_dout;
`ifdef TAG_RAM_CTRL_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif
    logic [8:0] mem [8];
    logic [2:0] rd_addr = '0;
    int n_chk = 0;
    int n_fail = 0;

    tag_ram_ctrl dut (
        .clock(clock), .reset(reset),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_index(lk_index), .lk_tag(lk_tag),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_index(rsp_index),
        .up_valid(up_valid), .up_ready(up_ready), .up_index(up_index), .up_tag(up_tag),
        .up_set_valid(up_set_valid), .flush_req(flush_req), .init_done(init_done),
`ifdef TAG_RAM_CTRL_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clock = ~clock;

    initial for (int i = 0; i < 8; i++) mem[i] = {1'b1, 8'h50 + 8'(i)};

    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        rd_addr <= ram_addr;
    end
    assign ram_dout = mem[rd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #3;
        chk("rst_lk_ready", 32'(lk_ready), 0);
        chk("rst_up_ready", 32'(up_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_hit", 32'(rsp_hit), 0);
        chk("rst_rsp_index", 32'(rsp_index), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_din", 32'(ram_din), 0);
        tick(); tick();
        reset = 1'b0; lk_valid = 1'b1; up_valid = 1'b1;
        #1;
        chk("init_lk_ready", 32'(lk_ready), 0);
        chk("init_up_ready", 32'(up_ready), 0);
        lk_valid = 1'b0; up_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("sweep_we", 32'(ram_we), 1);
            chk("sweep_addr", 32'(ram_addr), 32'(i));
            chk("sweep_din", 32'(ram_din), 0);
            chk("sweep_init_done", 32'(init_done), 0);
            tick(); #1;
        end
        chk("run_init_done", 32'(init_done), 1);
        chk("run_idle_we", 32'(ram_we), 0);
        chk("run_idle_addr", 32'(ram_addr), 0);
        // stale pre-reset contents must have been cleared
        lk_valid = 1'b1; lk_index = 3'd2; lk_tag = 8'h52;
        #1;
        chk("lk2_ready", 32'(lk_ready), 1);
        chk("lk2_addr", 32'(ram_addr), 2);
        chk("lk2_we", 32'(ram_we), 0);
        tick();
        lk_valid = 1'b0;
        #1;
        chk("lk2_rsp_valid", 32'(rsp_valid), 1);
        chk("lk2_rsp_hit", 32'(rsp_hit), 0);
        chk("lk2_rsp_index", 32'(rsp_index), 2);
        // fill 3/A5 then hit and miss lookups back to back
        up_valid = 1'b1; up_index = 3'd3; up_tag = 8'hA5; up_set_valid = 1'b1;
        #1;
        chk("fill3_ready", 32'(up_ready), 1);
        chk("fill3_we", 32'(ram_we), 1);
        chk("fill3_addr", 32'(ram_addr), 3);
        chk("fill3_din", 32'(ram_din), 32'h1A5);
        tick();
        up_valid = 1'b0; lk_valid = 1'b1; lk_index = 3'd3; lk_tag = 8'hA5;
        #1;
        chk("lk3_ready", 32'(lk_ready), 1);
        chk("lk3_no_rsp", 32'(rsp_valid), 0);
        tick();
        lk_tag = 8'hA4;
        #1;
        chk("lk3_rsp_valid", 32'(rsp_valid), 1);
        chk("lk3_hit", 32'(rsp_hit), 1);
        chk("lk3_rsp_index", 32'(rsp_index), 3);
        tick();
        lk_valid = 1'b0;
        #1;
        chk("lk3a4_rsp_valid", 32'(rsp_valid), 1);
        chk("lk3a4_hit", 32'(rsp_hit), 0);
        tick(); #1;
        chk("lk3_rsp_done", 32'(rsp_valid), 0);
        // invalidate 3 then lookup misses
        up_valid = 1'b1; up_set_valid = 1'b0; up_tag = 8'hA5;
        #1;
        chk("inv3_din", 32'(ram_din), 32'h0A5);
        chk("inv3_we", 32'(ram_we), 1);
        tick();
        up_valid = 1'b0; lk_valid = 1'b1; lk_tag = 8'hA5;
        #1;
        chk("inv3_lk_ready", 32'(lk_ready), 1);
        tick();
        lk_valid = 1'b0;
        #1;
        chk("inv3_rsp_valid", 32'(rsp_valid), 1);
        chk("inv3_hit", 32'(rsp_hit), 0);
        // contention: U,L,U,L
        tick();
        up_valid = 1'b1; up_index = 3'd6; up_tag = 8'h11; up_set_valid = 1'b1;
        lk_valid = 1'b1; lk_index = 3'd6; lk_tag = 8'h11;
        #1;
        chk("rr0_up", 32'(up_ready), 1);
        chk("rr0_lk", 32'(lk_ready), 0);
        chk("rr0_rsp", 32'(rsp_valid), 0);
        tick(); #1;
        chk("rr1_lk", 32'(lk_ready), 1);
        chk("rr1_up", 32'(up_ready), 0);
        chk("rr1_addr", 32'(ram_addr), 6);
        chk("rr1_rsp", 32'(rsp_valid), 0);
        tick(); #1;
        chk("rr2_up", 32'(up_ready), 1);
        chk("rr2_lk", 32'(lk_ready), 0);
        chk("rr2_rsp", 32'(rsp_valid), 1);
        chk("rr2_hit", 32'(rsp_hit), 1);
        tick(); #1;
        chk("rr3_lk", 32'(lk_ready), 1);
        chk("rr3_rsp", 32'(rsp_valid), 0);
        tick();
        up_valid = 1'b0; lk_valid = 1'b0;
        #1;
        chk("rr4_rsp", 32'(rsp_valid), 1);
        chk("rr4_hit", 32'(rsp_hit), 1);
        chk("rr4_lk", 32'(lk_ready), 0);
        tick(); #1;
        chk("rr5_rsp", 32'(rsp_valid), 0);
        // fill 5, lookup, then flush while response is in flight
        up_valid = 1'b1; up_index = 3'd5; up_tag = 8'h3C; up_set_valid = 1'b1;
        #1;
        chk("fill5_ready", 32'(up_ready), 1);
        tick();
        up_valid = 1'b0; lk_valid = 1'b1; lk_index = 3'd5; lk_tag = 8'h3C;
        #1;
        chk("lk5_ready", 32'(lk_ready), 1);
        tick();
        lk_valid = 1'b0; flush_req = 1'b1; up_valid = 1'b1;
        #1;
        chk("flush_rsp_valid", 32'(rsp_valid), 1);
        chk("flush_rsp_hit", 32'(rsp_hit), 1);
        chk("flush_up_ready", 32'(up_ready), 0);
        chk("flush_we", 32'(ram_we), 0);
        chk("flush_init_done", 32'(init_done), 1);
        tick();
        flush_req = 1'b0; up_valid = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("fsweep_init_done", 32'(init_done), 0);
            chk("fsweep_we", 32'(ram_we), 1);
            chk("fsweep_addr", 32'(ram_addr), 32'(i));
            tick(); #1;
        end
        chk("fsweep_done", 32'(init_done), 1);
        lk_valid = 1'b1;
        #1;
        chk("lk5b_ready", 32'(lk_ready), 1);
        tick();
        lk_valid = 1'b0;
        #1;
        chk("lk5b_rsp_valid", 32'(rsp_valid), 1);
        chk("lk5b_hit", 32'(rsp_hit), 0);
        // reset mid-sweep at counter 4
        tick();
        flush_req = 1'b1;
        #1;
        tick();
        flush_req = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rsweep_addr", 32'(ram_addr), 32'(i));
            tick(); #1;
        end
        chk("rsweep_addr4", 32'(ram_addr), 4);
        chk("rsweep_we4", 32'(ram_we), 1);
        reset = 1'b1;
        #1;
        chk("midrst_we", 32'(ram_we), 0);
        chk("midrst_addr", 32'(ram_addr), 0);
        chk("midrst_init_done", 32'(init_done), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        tick(); tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("rsweep2_we", 32'(ram_we), 1);
            chk("rsweep2_addr", 32'(ram_addr), 32'(i));
            tick(); #1;
        end
        chk("rsweep2_done", 32'(init_done), 1);
        // 3 hits, 2 misses
        up_valid = 1'b1; up_index = 3'd1; up_tag = 8'h77; up_set_valid = 1'b1;
        #1;
        tick();
        up_valid = 1'b0; lk_valid = 1'b1; lk_index = 3'd1; lk_tag = 8'h77;
        #1;
        tick(); #1;
        chk("st1_rsp", 32'(rsp_valid), 1);
        chk("st1_hit", 32'(rsp_hit), 1);
        tick();
        lk_tag = 8'h78;
        #1;
        chk("st2_hit", 32'(rsp_hit), 1);
        tick();
        lk_tag = 8'h77;
        #1;
        chk("st3_hit", 32'(rsp_hit), 0);
        chk("st3_rsp", 32'(rsp_valid), 1);
        tick();
        lk_index = 3'd2; lk_tag = 8'h00;
        #1;
        chk("st4_hit", 32'(rsp_hit), 1);
        tick();
        lk_valid = 1'b0;
        #1;
        chk("st5_rsp", 32'(rsp_valid), 1);
        chk("st5_hit", 32'(rsp_hit), 0);
        chk("st5_index", 32'(rsp_index), 2);
        tick(); #1;
        chk("st_idle", 32'(rsp_valid), 0);
`ifdef TAG_RAM_CTRL_STATS_EN
        chk("hit_count", 32'(hit_count), 3);
        chk("miss_count", 32'(miss_count), 2);
`endif
        // in-flight response dropped by reset
        lk_valid = 1'b1; lk_index = 3'd1; lk_tag = 8'h77;
        #1;
        chk("drop_lk_ready", 32'(lk_ready), 1);
        tick();
        lk_valid = 1'b0; reset = 1'b1;
        #1;
        chk("drop_rsp_valid", 32'(rsp_valid), 0);
        chk("drop_rsp_hit", 32'(rsp_hit), 0);
`ifdef TAG_RAM_CTRL_STATS_EN
        chk("drop_hit_count", 32'(hit_count), 0);
`endif
        tick();
        reset = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
